// File: rtl/audio_sdm_mixer.sv
// Sound output stage: mixes beeper/tape/Soundrive sources per channel, slew-limits
// the mixed level and emits a first-order sigma-delta bitstream for an external RC filter.
module audio_sdm_mixer #(
    parameter int SAMPLE_DIV = 8,
    parameter int BEEPER_W   = 128,
    parameter int TAPE_OUT_W = 64,
    parameter int TAPE_IN_W  = 32,
    parameter int SLEW       = 4
) (
    input  logic       clk28,
    input  logic       usrrst_n,
    input  logic       beeper,
    input  logic       tape_out,
    input  logic       tape_in,
    input  logic       mute,
    input  logic [7:0] sd_l0,
    input  logic [7:0] sd_l1,
    input  logic [7:0] sd_r0,
    input  logic [7:0] sd_r1,
    output logic       dac_l,
    output logic       dac_r
);

    localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [9:0]  SLEW_V   = 10'(SLEW);
    localparam logic [11:0] BEEPER_V = 12'(BEEPER_W);
    localparam logic [11:0] TOUT_V   = 12'(TAPE_OUT_W);
    localparam logic [11:0] TIN_V    = 12'(TAPE_IN_W);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tape_in_m_q, tape_in_s_q;
    logic [9:0]       target_l_q, target_l_d, target_r_q, target_r_d;
    logic [9:0]       level_l_q, level_l_d, level_r_q, level_r_d;
    logic [9:0]       acc_l_q, acc_l_d, acc_r_q, acc_r_d;
    logic             dac_l_q, dac_l_d, dac_r_q, dac_r_d;
    logic             tick;
    logic [11:0]      common, sum_l, sum_r;

    // Moves lvl toward tgt by at most SLEW; the step is clamped to the gap so it never overshoots.
    function automatic logic [9:0] slew_step(input logic [9:0] lvl, input logic [9:0] tgt);
        logic [9:0] gap;
        logic [9:0] res;
        res = lvl;
        if (lvl < tgt) begin
            gap = tgt - lvl;
            res = lvl + ((gap > SLEW_V) ? SLEW_V : gap);
        end else if (lvl > tgt) begin
            gap = lvl - tgt;
            res = lvl - ((gap > SLEW_V) ? SLEW_V : gap);
        end
        return res;
    endfunction

    function automatic logic [9:0] sat10(input logic [11:0] s);
        return (s > 12'd1023) ? 10'd1023 : s[9:0];
    endfunction

    always_comb begin
        tick   = (div_q == DIV_LAST);
        div_d  = tick ? '0 : div_q + 1'b1;

        common = (beeper ? BEEPER_V : 12'd0) + (tape_out ? TOUT_V : 12'd0)
               + (tape_in_s_q ? TIN_V : 12'd0);
        sum_l  = {4'd0, sd_l0} + {4'd0, sd_l1} + common;
        sum_r  = {4'd0, sd_r0} + {4'd0, sd_r1} + common;

        target_l_d = target_l_q;
        target_r_d = target_r_q;
        level_l_d  = level_l_q;
        level_r_d  = level_r_q;
        if (tick) begin
            target_l_d = mute ? 10'd0 : sat10(sum_l);
            target_r_d = mute ? 10'd0 : sat10(sum_r);
            level_l_d  = slew_step(level_l_q, target_l_q);
            level_r_d  = slew_step(level_r_q, target_r_q);
        end

        // The carry out of the 10-bit accumulator is the output bit.
        {dac_l_d, acc_l_d} = {1'b0, acc_l_q} + {1'b0, level_l_q};
        {dac_r_d, acc_r_d} = {1'b0, acc_r_q} + {1'b0, level_r_q};
    end

    always_ff @(posedge clk28 or negedge usrrst_n) begin
        if (!usrrst_n) begin
            div_q       <= '0;
            tape_in_m_q <= 1'b0;
            tape_in_s_q <= 1'b0;
            target_l_q  <= '0;
            target_r_q  <= '0;
            level_l_q   <= '0;
            level_r_q   <= '0;
            acc_l_q     <= '0;
            acc_r_q     <= '0;
            dac_l_q     <= 1'b0;
            dac_r_q     <= 1'b0;
        end else begin
            div_q       <= div_d;
            tape_in_m_q <= tape_in;
            tape_in_s_q <= tape_in_m_q;
            target_l_q  <= target_l_d;
            target_r_q  <= target_r_d;
            level_l_q   <= level_l_d;
            level_r_q   <= level_r_d;
            acc_l_q     <= acc_l_d;
            acc_r_q     <= acc_r_d;
            dac_l_q     <= dac_l_d;
            dac_r_q     <= dac_r_d;
        end
    end

    assign dac_l = dac_l_q;
    assign dac_r = dac_r_q;

endmodule

// File: tb/tb_audio_sdm_mixer.sv
// Bench for audio_sdm_mixer: per-tick level ramps via an expected queue, exact
// 1024-cycle bitstream densities, async reset behaviour and a saturating instance.
module tb_audio_sdm_mixer;

    logic       clk28 = 1'b0;
    logic       usrrst_n, sat_rst_n;
    logic       beeper, tape_out, tape_in, mute;
    logic [7:0] sd_l0, sd_l1, sd_r0, sd_r1;
    logic       dac_l, dac_r, sat_dac_l, sat_dac_r;

    logic       s_beeper = 1'b1, s_tape_out = 1'b1, s_zero = 1'b0;
    logic [7:0] s_full = 8'd255, s_none = 8'd0;

    int total = 0;
    int bad   = 0;
    logic [19:0] exp_q[$];

    always #5 clk28 = ~clk28;

    audio_sdm_mixer dut (
        .clk28(clk28), .usrrst_n(usrrst_n), .beeper(beeper), .tape_out(tape_out),
        .tape_in(tape_in), .mute(mute), .sd_l0(sd_l0), .sd_l1(sd_l1),
        .sd_r0(sd_r0), .sd_r1(sd_r1), .dac_l(dac_l), .dac_r(dac_r)
    );

    // Beeper weight 512 plus tape_out and full Soundrive overflows 1023 on the left only.
    audio_sdm_mixer #(.BEEPER_W(512)) dut_sat (
        .clk28(clk28), .usrrst_n(sat_rst_n), .beeper(s_beeper), .tape_out(s_tape_out),
        .tape_in(s_zero), .mute(s_zero), .sd_l0(s_full), .sd_l1(s_full),
        .sd_r0(s_none), .sd_r1(s_none), .dac_l(sat_dac_l), .dac_r(sat_dac_r)
    );

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int step_to(input int cur, input int tgt);
        if (cur < tgt) return cur + ((tgt - cur > 4) ? 4 : tgt - cur);
        if (cur > tgt) return cur - ((cur - tgt > 4) ? 4 : cur - tgt);
        return cur;
    endfunction

    // Called right after inputs change, tick-aligned: the first tick only latches the
    // new target, levels start moving on the second.
    task automatic expect_ramp(input int l0, input int tl, input int r0, input int tr, input int n);
        int cl, cr;
        logic [19:0] e;
        cl = l0;
        cr = r0;
        for (int k = 1; k <= n; k++) begin
            if (k > 1) begin
                cl = step_to(cl, tl);
                cr = step_to(cr, tr);
            end
            exp_q.push_back({10'(cl), 10'(cr)});
        end
        for (int k = 1; k <= n; k++) begin
            repeat (8) @(posedge clk28);
            #1;
            e = exp_q.pop_front();
            check("level_l", int'(dut.level_l_q), int'(e[19:10]));
            check("level_r", int'(dut.level_r_q), int'(e[9:0]));
        end
    endtask

    task automatic count_ones(input int n, output int cl, output int cr, output int cs);
        cl = 0;
        cr = 0;
        cs = 0;
        repeat (n) begin
            @(posedge clk28);
            #1;
            cl += int'(dac_l);
            cr += int'(dac_r);
            cs += int'(sat_dac_l);
        end
    endtask

    task automatic pulse_reset();
        usrrst_n = 1'b0;
        @(posedge clk28);
        #1;
        usrrst_n = 1'b1;
    endtask

    initial begin
        int cl, cr, cs;
        usrrst_n = 1'b0; sat_rst_n = 1'b0;
        beeper = 1'b0; tape_out = 1'b0; tape_in = 1'b0; mute = 1'b0;
        sd_l0 = 8'd0; sd_l1 = 8'd0; sd_r0 = 8'd0; sd_r1 = 8'd0;
        repeat (3) @(posedge clk28);
        #1;
        check("rst_dac_l", int'(dac_l), 0);
        check("rst_dac_r", int'(dac_r), 0);
        check("rst_level_l", int'(dut.level_l_q), 0);
        usrrst_n = 1'b1; sat_rst_n = 1'b1;

        // Idle: everything stays silent.
        expect_ramp(0, 0, 0, 0, 16);
        count_ones(4096, cl, cr, cs);
        check("idle_ones_l", cl, 0);
        check("idle_ones_r", cr, 0);

        // Full left Soundrive from reset.
        sd_l0 = 8'd255; sd_l1 = 8'd255;
        pulse_reset();
        expect_ramp(0, 510, 0, 0, 130);
        count_ones(1024, cl, cr, cs);
        check("sd_ones_l", cl, 510);
        check("sd_ones_r", cr, 0);

        // Beeper only: both channels settle at the beeper weight.
        sd_l0 = 8'd0; sd_l1 = 8'd0; beeper = 1'b1;
        expect_ramp(510, 128, 0, 128, 100);
        count_ones(1024, cl, cr, cs);
        check("beep_ones_l", cl, 128);
        check("beep_ones_r", cr, 128);

        // Back to full left, then mute together with an input change: mute wins.
        beeper = 1'b0; sd_l0 = 8'd255; sd_l1 = 8'd255;
        expect_ramp(128, 510, 128, 0, 100);
        mute = 1'b1; sd_l0 = 8'd100; sd_r0 = 8'd77;
        expect_ramp(510, 0, 0, 0, 130);
        count_ones(1024, cl, cr, cs);
        check("mute_ones_l", cl, 0);
        check("mute_ones_r", cr, 0);
        mute = 1'b0; sd_l0 = 8'd255; sd_r0 = 8'd0;
        expect_ramp(0, 510, 0, 0, 130);

        // tape_out plus asynchronous tape_in reach the target on the next tick.
        sd_l0 = 8'd0; sd_l1 = 8'd0; tape_out = 1'b1; tape_in = 1'b1;
        expect_ramp(510, 96, 0, 96, 110);
        count_ones(1024, cl, cr, cs);
        check("tape_ones_l", cl, 96);
        check("tape_ones_r", cr, 96);
        tape_out = 1'b0; tape_in = 1'b0;
        expect_ramp(96, 0, 96, 0, 30);

        // Reset in the middle of a ramp at level 200, between clock edges.
        sd_l0 = 8'd255; sd_l1 = 8'd255;
        pulse_reset();
        expect_ramp(0, 510, 0, 0, 51);
        #2;
        usrrst_n = 1'b0;
        #1;
        check("mid_rst_dac_l", int'(dac_l), 0);
        check("mid_rst_level_l", int'(dut.level_l_q), 0);
        check("mid_rst_target_l", int'(dut.target_l_q), 0);
        check("mid_rst_acc_l", int'(dut.acc_l_q), 0);
        @(posedge clk28);
        #1;
        check("held_rst_dac_l", int'(dac_l), 0);
        usrrst_n = 1'b1;
        expect_ramp(0, 510, 0, 0, 10);

        // Saturating instance has long since settled.
        check("sat_target_l", int'(dut_sat.target_l_q), 1023);
        check("sat_level_l", int'(dut_sat.level_l_q), 1023);
        check("sat_level_r", int'(dut_sat.level_r_q), 576);
        count_ones(1024, cl, cr, cs);
        check("sat_ones_l", cs, 1023);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
